// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants, immediate range limits and the
// decoded-field bundle used by the instruction encoder.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    localparam logic [FMT_W-1:0] FMT_R = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J = 3'd5;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;

    // Inclusive signed limits on the full 32-bit immediate
    localparam logic signed [XLEN-1:0] IS_MIN = 32'shFFFF_F800;
    localparam logic signed [XLEN-1:0] IS_MAX = 32'sh0000_07FF;
    localparam logic signed [XLEN-1:0] B_MIN  = 32'shFFFF_F000;
    localparam logic signed [XLEN-1:0] B_MAX  = 32'sh0000_0FFE;
    localparam logic signed [XLEN-1:0] J_MIN  = 32'shFFF0_0000;
    localparam logic signed [XLEN-1:0] J_MAX  = 32'sh000F_FFFE;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
    } fields_t;

    function automatic logic in_range(input logic signed [XLEN-1:0] v,
                                      input logic signed [XLEN-1:0] lo,
                                      input logic signed [XLEN-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the encoder.
interface imm_encoder_if
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [FMT_W-1:0] fmt;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [XLEN-1:0]  imm;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/imm_pack.sv
// Combinational scatter of decoded fields into a 32-bit instruction word,
// with immediate range checking and NOP substitution on rejection.
module imm_pack
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
    input  fields_t         f,
    output logic [XLEN-1:0] word,
    output logic            err
);

    logic signed [XLEN-1:0] simm;
    logic [XLEN-1:0]        raw;
    logic                   bad;

    assign simm = $signed(f.imm);

    always_comb begin
        raw = '0;
        bad = 1'b0;
        case (f.fmt)
            FMT_R: raw = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: begin
                raw = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                bad = !in_range(simm, IS_MIN, IS_MAX);
            end
            FMT_S: begin
                raw = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
                bad = !in_range(simm, IS_MIN, IS_MAX);
            end
            FMT_B: begin
                raw = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                       f.imm[4:1], f.imm[11], f.opcode};
                bad = !in_range(simm, B_MIN, B_MAX) || f.imm[0];
            end
            FMT_U: begin
                raw = {f.imm[31:12], f.rd, f.opcode};
                bad = (f.imm[11:0] != 12'd0);
            end
            FMT_J: begin
                raw = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
                bad = !in_range(simm, J_MIN, J_MAX) || f.imm[0];
            end
            default: bad = 1'b1;
        endcase
        word = bad ? NOP_WORD : raw;
        err  = bad;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage streaming RISC-V instruction encoder: registers decoded fields,
// tags each with an auto-incrementing byte address and emits the packed word.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [XLEN-1:0]   NOP_WORD  = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    imm_encoder_if.slave bus,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    logic              s1_valid;
    fields_t           s1_f;
    logic [ADDR_W-1:0] s1_addr;
    logic [ADDR_W-1:0] addr_cnt;

    fields_t           in_f_c;
    logic              s2_ready_c;
    logic              in_xfer_c;
    logic              out_xfer_c;
    logic [ADDR_W-1:0] slot_addr_c;
    logic [XLEN-1:0]   word_c;
    logic              err_c;

    assign s2_ready_c  = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_ready_c;
    assign in_xfer_c   = bus.in_valid && bus.in_ready;
    assign out_xfer_c  = bus.out_valid && bus.out_ready;
    // clr on an accepting cycle hands the word the base address
    assign slot_addr_c = clr ? BASE_ADDR : addr_cnt;

    always_comb begin
        in_f_c        = '0;
        in_f_c.fmt    = bus.fmt;
        in_f_c.opcode = bus.opcode;
        in_f_c.rd     = bus.rd;
        in_f_c.rs1    = bus.rs1;
        in_f_c.rs2    = bus.rs2;
        in_f_c.funct3 = bus.funct3;
        in_f_c.funct7 = bus.funct7;
        in_f_c.imm    = bus.imm;
    end

    // Address counter: wraps naturally modulo 2^ADDR_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt <= BASE_ADDR;
        end else if (in_xfer_c) begin
            addr_cnt <= slot_addr_c + ADDR_W'(4);
        end else if (clr) begin
            addr_cnt <= BASE_ADDR;
        end
    end

    // Stage 1: capture fields and their address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_addr  <= BASE_ADDR;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_f    <= in_f_c;
                s1_addr <= slot_addr_c;
            end
        end
    end

    imm_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .f    (s1_f),
        .word (word_c),
        .err  (err_c)
    );

    // Stage 2: encoded word; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= BASE_ADDR;
            bus.out_err   <= 1'b0;
        end else if (s2_ready_c) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_instr <= word_c;
                bus.out_addr  <= s1_addr;
                bus.out_err   <= err_c;
            end
        end
    end

    // Rejected words are counted once they leave; clr takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (out_xfer_c && bus.out_err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected words queued on accept,
// compared when the encoder presents them.
module tb_imm_encoder;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] err_cnt;

    exp_t        q[$];
    logic [31:0] exp_addr = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    logic        bp_done = 1'b0;

    imm_encoder_if #(.ADDR_W(32)) bus ();

    imm_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .NOP_WORD  (32'h0000_0013)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every presented word is checked against the queue head
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                check("instr", 64'(bus.out_instr), 64'(q[0].instr));
                check("addr",  64'(bus.out_addr),  64'(q[0].addr));
                check("err",   64'(bus.out_err),   64'(q[0].err));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_w, input logic exp_e, input logic with_clr);
        int   n;
        exp_t e;
        bus.fmt = fmt; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
        bus.in_valid = 1'b1;
        clr = with_clr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        if (with_clr) exp_addr = '0;
        e.instr = exp_w; e.addr = exp_addr; e.err = exp_e;
        q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        n_acc++;
        #1;
        bus.in_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_out_addr",  64'(bus.out_addr),  64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_err_cnt",   64'(err_cnt),       64'd0);
        @(posedge clk); #1;

        // ADDI x1, x0, 5 with latency check
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_s1_only", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_out", 64'(bus.out_valid), 64'd1);
        drain();

        // Back-to-back S/B, then J/U/R and range boundaries
        pulse_clr();
        send(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0);
        send(FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0, 1'b0);
        send(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0);
        send(FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      32'h7FF0_0093, 1'b0, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0000_0013, 1'b1, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0005, 32'h0000_0013, 1'b1, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,      32'h7E00_0FE3, 1'b0, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h0000_0013, 1'b1, 1'b0);
        send(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0, 1'b0);
        send(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1, 1'b0);
        send(3'd7,  OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 1'b1, 1'b0);
        drain();
        check("err_cnt_boundary", 64'(err_cnt), 64'd5);

        // Error group: addresses 0, 4, 8 and three counted rejections
        pulse_clr();
        check("err_cnt_clr", 64'(err_cnt), 64'd0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,   32'h0000_0013, 1'b1, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,      32'h0000_0013, 1'b1, 1'b0);
        send(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1001,   32'h0000_0013, 1'b1, 1'b0);
        drain();
        check("err_cnt_3", 64'(err_cnt), 64'd3);

        // Backpressure: three words offered while the consumer stalls
        pulse_clr();
        n_acc = 0;
        bus.out_ready = 1'b0;
        fork
            begin
                send(FMT_R, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_80B3, 1'b0, 1'b0);
                send(FMT_R, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_8133, 1'b0, 1'b0);
                send(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0, 1'b0);
                bp_done = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_accepts",  64'(n_acc),        64'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
        check("bp_done", 64'(bp_done), 64'd1);
        #1;
        drain();

        // Reset with both stages full discards the words
        bus.out_ready = 1'b0;
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0, 1'b0);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0093, 1'b0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_addr = '0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_addr",  64'(bus.out_addr),  64'd0);
        check("mid_rst_err_cnt",   64'(err_cnt),       64'd0);
        repeat (5) @(negedge clk);
        check("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // clr coincident with accept restarts addressing at that word
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0, 1'b0);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0093, 1'b0, 1'b0);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0093, 1'b0, 1'b1);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0093, 1'b0, 1'b0);
        drain();

        // clr coincident with an errored output transfer wins
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0013, 1'b1, 1'b0);
        drain();
        check("err_cnt_pre_clr", 64'(err_cnt), 64'd1);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5000, 32'h0000_0013, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("err_out_present", 64'(bus.out_valid & bus.out_err), 64'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_addr = '0;
        check("err_cnt_clr_wins", 64'(err_cnt), 64'd0);
        check("clr_q_empty", 64'(q.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming RISC-V instruction encoder; the inverse of the immediate generator.
- Accepts decoded fields (format, opcode, registers, functs, 32-bit signed immediate) over a valid/ready handshake.
- Range-checks the immediate, scatters it into the architectural bit positions, and emits a 32-bit instruction word tagged with an auto-incrementing byte address for instruction-memory loading.
- Sits between the program-load path and the instruction-memory write port.

Parameters:
- ADDR_W, 32, width of the emitted address.
- BASE_ADDR, 0, address counter value after reset/clr.
- NOP_WORD, 32'h00000013, word substituted for any rejected instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clr  in  1  reload address counter to BASE_ADDR; zero err_cnt
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- fmt  in  3  format code (shared package)
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3
- funct7  in  7  funct7
- imm  in  32  signed byte-offset/immediate, two's complement
- out_valid  out  1  word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_instr
- out_err  out  1  immediate rejected; out_instr = NOP_WORD
- err_cnt  out  16  saturating count of rejected instructions

Behaviour:
- Reset (rst_n low at a clk edge) clears both pipeline valids; the address counter loads BASE_ADDR and err_cnt loads 0. After reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, in_ready=1. Reset mid-operation discards in-flight words without emitting them.
- Pipeline has two stages:
  - S1 registers the fields, assigns the current address counter value, and advances the counter by 4. The counter wraps modulo 2^ADDR_W.
  - S2 registers the encoded word, out_err and the address.
- Latency: out_valid asserts 2 cycles after the accepting edge when out_ready is high.
- Handshake:
  - An input transfer occurs on in_valid & in_ready.
  - An output transfer occurs on out_valid & out_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready (full throughput at out_ready=1).
  - Outputs hold stable while out_valid & !out_ready.
  - Words are never dropped or reordered.
- Field placement by format:
  - R: funct7|rs2|rs1|funct3|rd|opcode; imm ignored; never an error.
  - I: imm[11:0]|rs1|funct3|rd|opcode. Legal range -2048..2047.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode. Legal range -2048..2047.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode. Legal range -4096..4094; imm[0] must be 0.
  - U: imm[31:12]|rd|opcode. imm[11:0] must be 0.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode. Legal range -2^20..2^20-2; imm[0] must be 0.
  - Undefined fmt: error.
- On error: out_instr=NOP_WORD, out_err=1, and the address still consumes a slot. err_cnt increments when the errored word is accepted at the output, and saturates at 16'hFFFF.
- clr:
  - Affects only the counter and err_cnt; pipeline contents are kept.
  - clr in the same cycle as an input transfer: the accepted word gets BASE_ADDR, and the counter becomes BASE_ADDR+4.
  - clr in the same cycle as an errored output transfer: err_cnt becomes 0 (clr wins).
- Width rules: range checks are done on the full 32-bit signed imm, with no truncation before the check.

Decomposition:
- Shared package riscv_pkg:
  - fmt codes: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
  - Opcode constants: OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Range limits.
  - NOP constant.
- One combinational sub-module, imm_pack: fields → {word, err}. It is instantiated between S1 and S2 and owns all scatter and range-check logic.

Test Plan:
- I-type ADDI: fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → out_instr=0x00500093, out_addr=0, out_err=0, out_valid exactly 2 cycles after accept.
- S-type SW and B-type BEQ back-to-back:
  - SW: fmt=S, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 → 0x0020A423 @ addr 0.
  - BEQ: fmt=B, opcode=0x63, rs1=rs2=0, imm=-4 → 0xFE000EE3 @ addr 4.
- J-type JAL and U-type LUI:
  - JAL: fmt=J, opcode=0x6F, rd=1, imm=2048 → 0x001000EF.
  - LUI: fmt=U, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- Errors:
  - I imm=4096 → out_instr=0x00000013, out_err=1.
  - B imm=3 → out_err=1.
  - U imm=0x1001 → out_err=1.
  - After the three, err_cnt=3 and the addresses are 0, 4, 8.
- Backpressure: hold out_ready=0 for 5 cycles while offering 3 words → in_ready falls after 2 accepts; release → words emerge in order at addrs 0, 4, 8, with outputs stable while stalled.
- Reset/clr:
  - rst_n low 1 cycle with both stages full → next cycle out_valid=0, out_addr=BASE_ADDR, and no stale words appear.
  - clr coincident with accept → that word has addr 0 and the next has addr 4.
